// File: rtl/arb8_pkg.sv
// Shared types and helpers for the 8-way round-robin select arbiter.
//   N_REQ    : number of requesters (fixed at 8)
//   IDX_W    : width of a requester index
//   arb_state_t : arbiter FSM states
//   onehot8  : index -> one-hot select decode
//   inc_wrap : index + 1 with natural 3-bit wrap (7 -> 0)
package arb8_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        GAP
    } arb_state_t;

    function automatic logic [N_REQ-1:0] onehot8(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] idx);
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: the first set request scanning from ptr
// upward (modulo 8).
//   req : request lines
//   ptr : index with highest priority this round
//   any : at least one request is set
//   idx : winning index (meaningful only when any=1)
module rr_priority_pick
    import arb8_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;

    always_comb begin
        // Rotate so that req[ptr] lands at bit 0; ptr=0 gives a zero left shift term.
        rot = (req >> ptr) | (req << (4'(N_REQ) - {1'b0, ptr}));
        any = |rot;
        off = '0;
        // Descending scan so the lowest set bit is the last one written.
        for (int unsigned i = N_REQ; i > 0; i--) begin
            if (rot[i-1]) begin
                off = IDX_W'(i - 1);
            end
        end
        idx = off + ptr;
    end

endmodule

// File: rtl/rr_grant_arbiter8.sv
// Round-robin arbiter sharing one decoded select bus among 8 requesters.
// Holds a grant until done, request drop, or MAX_HOLD cycles, then inserts
// one dead (GAP) cycle before the next grant.
//   clk         : clock, rising edge
//   reset       : synchronous, active-high
//   req         : request lines
//   done        : owner releases the bus this cycle (ignored when idle)
//   grant       : registered one-hot select, zero when no owner
//   grant_idx   : binary owner index, qualified by grant_valid
//   grant_valid : high while grant is non-zero
//   timeout     : one-cycle pulse in the GAP after a MAX_HOLD-only release
module rr_grant_arbiter8
    import arb8_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout
);

    localparam int HCNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam bit HOLD_EN = (MAX_HOLD != 0);

    arb_state_t        state, state_n;
    logic [IDX_W-1:0]  ptr, ptr_n;
    logic [HCNT_W-1:0] hold_cnt, hold_cnt_n;
    logic [N_REQ-1:0]  grant_n;
    logic [IDX_W-1:0]  grant_idx_n;
    logic              grant_valid_n;
    logic              timeout_n;

    logic              pick_any;
    logic [IDX_W-1:0]  pick_idx;
    logic              rel_done, rel_drop, rel_lim;

    rr_priority_pick u_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        state_n       = state;
        ptr_n         = ptr;
        hold_cnt_n    = hold_cnt;
        grant_n       = grant;
        grant_idx_n   = grant_idx;
        grant_valid_n = grant_valid;
        timeout_n     = 1'b0;
        rel_done      = 1'b0;
        rel_drop      = 1'b0;
        rel_lim       = 1'b0;

        case (state)
            IDLE, GAP: begin
                if (pick_any) begin
                    state_n       = BUSY;
                    grant_n       = onehot8(pick_idx);
                    grant_idx_n   = pick_idx;
                    grant_valid_n = 1'b1;
                    hold_cnt_n    = '0;
                end else begin
                    state_n       = IDLE;
                    grant_n       = '0;
                    grant_valid_n = 1'b0;
                end
            end
            BUSY: begin
                rel_done = done;
                rel_drop = ~req[grant_idx];
                rel_lim  = HOLD_EN && (hold_cnt == HOLD_LAST);
                if (rel_done || rel_drop || rel_lim) begin
                    state_n       = GAP;
                    grant_n       = '0;
                    grant_valid_n = 1'b0;
                    ptr_n         = inc_wrap(grant_idx);
                    hold_cnt_n    = '0;
                    // A limit hit that coincides with done/drop counts as a normal release.
                    timeout_n     = rel_lim && !rel_done && !rel_drop;
                end else begin
                    hold_cnt_n = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_n       = IDLE;
                grant_n       = '0;
                grant_valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            hold_cnt    <= hold_cnt_n;
            grant       <= grant_n;
            grant_idx   <= grant_idx_n;
            grant_valid <= grant_valid_n;
            timeout     <= timeout_n;
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter8.sv
module tb_rr_grant_arbiter8;

    localparam int MAX_HOLD = 16;

    logic       clk;
    logic       reset;
    logic       done;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    rr_grant_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] g;
        logic [2:0] i;
        logic       v;
        logic       t;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] obs_g[$];
    logic [2:0] obs_i[$];
    logic       obs_t[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: who owns the bus, how many cycles it has shown so far,
    // where the next scan starts, and the last owner index.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;
    int m_last  = 0;
    bit m_tmo   = 1'b0;

    task automatic model_step(input logic [7:0] r, input logic d, input logic rst);
        exp_t e;
        bit   drop;
        bit   lim;
        if (rst) begin
            m_owner = -1; m_held = 0; m_ptr = 0; m_last = 0; m_tmo = 1'b0;
        end else if (m_owner >= 0) begin
            drop = (r[m_owner] == 1'b0);
            lim  = (MAX_HOLD != 0) && (m_held == MAX_HOLD);
            if (d || drop || lim) begin
                m_tmo   = lim && !d && !drop;
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
                m_held  = 0;
            end else begin
                m_held++;
                m_tmo = 1'b0;
            end
        end else begin
            m_tmo = 1'b0;
            for (int k = 0; k < 8; k++) begin
                int c;
                c = (m_ptr + k) % 8;
                if (m_owner < 0 && r[c]) begin
                    m_owner = c;
                    m_last  = c;
                    m_held  = 1;
                end
            end
        end
        e.g = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
        e.i = 3'(m_last);
        e.v = (m_owner >= 0);
        e.t = m_tmo;
        sb.push_back(e);
    endtask

    task automatic step(input logic [7:0] r, input logic d, input logic rst);
        @(negedge clk);
        req   = r;
        done  = d;
        reset = rst;
        model_step(r, d, rst);
        cyc++;
    endtask

    // Monitor: every cycle the DUT presents a registered result for the
    // inputs applied before the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                obs_g.push_back(grant);
                obs_i.push_back(grant_idx);
                obs_t.push_back(timeout);
                total++;
                if ({grant, grant_idx, grant_valid, timeout} !== {e.g, e.i, e.v, e.t}) begin
                    bad++;
                    $display("FAIL model cycle %0d: got grant=%h idx=%0d valid=%b timeout=%b, want grant=%h idx=%0d valid=%b timeout=%b",
                             obs_g.size() - 1, grant, grant_idx, grant_valid, timeout, e.g, e.i, e.v, e.t);
                end
                total++;
                if (!$onehot0(grant) || (grant_valid !== (|grant))) begin
                    bad++;
                    $display("FAIL invariant cycle %0d: grant=%h valid=%b", obs_g.size() - 1, grant, grant_valid);
                end
            end
        end
    end

    task automatic check_obs(input string name, input int k, input logic [7:0] g, input logic t, input int ci);
        total++;
        if (k >= obs_g.size()) begin
            bad++;
            $display("FAIL %s: cycle %0d never observed (have %0d)", name, k, obs_g.size());
        end else if (obs_g[k] !== g || obs_t[k] !== t || (ci >= 0 && obs_i[k] !== 3'(ci))) begin
            bad++;
            $display("FAIL %s: cycle %0d got grant=%h timeout=%b idx=%0d, want grant=%h timeout=%b idx=%0d",
                     name, k, obs_g[k], obs_t[k], obs_i[k], g, t, ci);
        end
    endtask

    int s1, s2, s3, s4, s5, s6, s7;

    initial begin
        logic [7:0] r;
        logic       d;
        reset = 1'b1;
        req   = '0;
        done  = 1'b0;

        step(8'h00, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b1);

        // Idle with no requests.
        s1 = cyc;
        repeat (5) step(8'h00, 1'b0, 1'b0);

        // Two requesters, release by done after three grant cycles.
        step(8'h00, 1'b0, 1'b1);
        s2 = cyc;
        step(8'h11, 1'b0, 1'b0);
        step(8'h11, 1'b0, 1'b0);
        step(8'h11, 1'b0, 1'b0);
        step(8'h11, 1'b1, 1'b0);
        step(8'h11, 1'b0, 1'b0);
        step(8'h11, 1'b1, 1'b0);

        // All requesting, done on every second grant cycle: full rotation with wrap.
        step(8'h00, 1'b0, 1'b1);
        s3 = cyc;
        for (int k = 0; k < 27; k++) begin
            d = (m_owner >= 0) && (m_held == 2);
            step(8'hFF, d, 1'b0);
        end

        // Hold limit expiry.
        step(8'h00, 1'b0, 1'b1);
        s4 = cyc;
        repeat (18) step(8'h04, 1'b0, 1'b0);

        // done coinciding with the limit cycle.
        step(8'h00, 1'b0, 1'b1);
        s5 = cyc;
        for (int k = 0; k < 18; k++) step(8'h04, (k == 16), 1'b0);

        // Request drop on the sixth grant cycle.
        step(8'h00, 1'b0, 1'b1);
        s6 = cyc;
        for (int k = 0; k < 8; k++) step((k == 6) ? 8'h00 : 8'h04, 1'b0, 1'b0);

        // Reset mid-grant.
        step(8'h00, 1'b0, 1'b1);
        s7 = cyc;
        step(8'h20, 1'b0, 1'b0);
        step(8'hA0, 1'b0, 1'b1);
        step(8'hA0, 1'b0, 1'b0);

        // Random traffic: sticky requests, varying done density, rare resets.
        r = 8'h00;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                r = ($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
            end
            d = (k < 700) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 4) == 0);
            step(r, d, ($urandom_range(0, 199) == 0));
        end
        step(8'h00, 1'b0, 1'b0);

        for (int n = 0; n < 10 && sb.size() > 0; n++) begin
            @(posedge clk);
            #2;
        end
        total++;
        if (sb.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d expected results never presented", sb.size());
        end

        for (int k = 0; k < 5; k++) check_obs("idle", s1 + k, 8'h00, 1'b0, -1);
        check_obs("s2_first",  s2,     8'h01, 1'b0, 0);
        check_obs("s2_third",  s2 + 2, 8'h01, 1'b0, 0);
        check_obs("s2_gap",    s2 + 3, 8'h00, 1'b0, -1);
        check_obs("s2_second", s2 + 4, 8'h10, 1'b0, 4);
        for (int k = 0; k < 9; k++) begin
            check_obs("rotate", s3 + 3 * k, 8'(1 << (k % 8)), 1'b0, k % 8);
            check_obs("rotate_gap", s3 + 3 * k + 2, 8'h00, 1'b0, -1);
        end
        check_obs("limit_first", s4,      8'h04, 1'b0, 2);
        check_obs("limit_last",  s4 + 15, 8'h04, 1'b0, 2);
        check_obs("limit_gap",   s4 + 16, 8'h00, 1'b1, -1);
        check_obs("limit_again", s4 + 17, 8'h04, 1'b0, 2);
        check_obs("done_at_lim_last", s5 + 15, 8'h04, 1'b0, 2);
        check_obs("done_at_lim_gap",  s5 + 16, 8'h00, 1'b0, -1);
        check_obs("drop_last",   s6 + 5, 8'h04, 1'b0, 2);
        check_obs("drop_gap",    s6 + 6, 8'h00, 1'b0, -1);
        check_obs("rst_grant",   s7,     8'h20, 1'b0, 5);
        check_obs("rst_clear",   s7 + 1, 8'h00, 1'b0, 0);
        check_obs("rst_regrant", s7 + 2, 8'h20, 1'b0, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
